// File: rtl/display_output_controller.sv
// rtl/display_output_controller.sv - CPU output port: 32-bit word to three 7-segment decimal digits.
// Sequential double-dabble conversion behind a ready/valid write handshake.
module display_output_controller #(
    parameter int DATA_WIDTH    = 32,
    parameter int BLANK_LEADING = 1,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  out_valid,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ready,
    output logic [6:0]            outputA,
    output logic [6:0]            outputB,
    output logic [6:0]            outputC
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MAX_SHOWN = DATA_WIDTH'(999);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam bit         BLANKING  = (BLANK_LEADING != 0);

    state_t      state;
    logic [9:0]  shift_q;
    logic [11:0] bcd_q;
    logic [3:0]  cnt;
    logic        ovf;

    logic [11:0] bcd_adj;
    logic [21:0] dabble;

    // Glyph table is written for the board's active-low segments.
    function automatic logic [6:0] seg_low(input logic [3:0] d);
        case (d)
            4'd0:    seg_low = 7'b1000000;
            4'd1:    seg_low = 7'b1111001;
            4'd2:    seg_low = 7'b0100100;
            4'd3:    seg_low = 7'b0110000;
            4'd4:    seg_low = 7'b0011001;
            4'd5:    seg_low = 7'b0010010;
            4'd6:    seg_low = 7'b0000010;
            4'd7:    seg_low = 7'b1111000;
            4'd8:    seg_low = 7'b0000000;
            4'd9:    seg_low = 7'b0010000;
            default: seg_low = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] drive(input logic [6:0] glyph_low);
        drive = (ACTIVE_LOW != 0) ? glyph_low : ~glyph_low;
    endfunction

    // One double-dabble step: correct nibbles >= 5, then shift the whole register left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        dabble = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            out_ready <= 1'b1;
            outputA   <= drive(SEG_ZERO);
            outputB   <= BLANKING ? drive(SEG_BLANK) : drive(SEG_ZERO);
            outputC   <= BLANKING ? drive(SEG_BLANK) : drive(SEG_ZERO);
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_ready <= 1'b0;
                        if (out_data > MAX_SHOWN) begin
                            ovf   <= 1'b1;
                            state <= UPDATE;
                        end else begin
                            ovf     <= 1'b0;
                            shift_q <= out_data[9:0];
                            bcd_q   <= '0;
                            cnt     <= '0;
                            state   <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    bcd_q   <= dabble[21:10];
                    shift_q <= dabble[9:0];
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd9)
                        state <= UPDATE;
                end
                UPDATE: begin
                    if (ovf) begin
                        outputA <= drive(SEG_DASH);
                        outputB <= drive(SEG_DASH);
                        outputC <= drive(SEG_DASH);
                    end else begin
                        outputA <= drive(seg_low(bcd_q[3:0]));
                        outputB <= (BLANKING && bcd_q[11:4] == 8'd0)
                                   ? drive(SEG_BLANK) : drive(seg_low(bcd_q[7:4]));
                        outputC <= (BLANKING && bcd_q[11:8] == 4'd0)
                                   ? drive(SEG_BLANK) : drive(seg_low(bcd_q[11:8]));
                    end
                    out_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_output_controller.sv
// tb/tb_display_output_controller.sv - scoreboard bench for display_output_controller.
// Two instances: board defaults, and BLANK_LEADING=0 with inverted segment polarity.
module tb_display_output_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        out_valid;
    logic [31:0] out_data;
    logic        ready1, ready2;
    logic [6:0]  a1, b1, c1, a2, b2, c2;

    always #5 clock = ~clock;

    display_output_controller u_dut1 (
        .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
        .out_ready(ready1), .outputA(a1), .outputB(b1), .outputC(c1)
    );

    display_output_controller #(.BLANK_LEADING(0), .ACTIVE_LOW(0)) u_dut2 (
        .clock(clock), .reset(reset), .out_valid(out_valid), .out_data(out_data),
        .out_ready(ready2), .outputA(a2), .outputB(b2), .outputC(c2)
    );

    typedef struct {
        logic [6:0] a1, b1, c1, a2, b2, c2;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   free_at = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   started = 1'b0;
    bit   pend_reset = 1'b0;
    logic prev_ready = 1'b0;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
            2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
            4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
            6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
            8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
            10: glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] v, input int acc);
        exp_t e;
        int h, t, o;
        e.acc = acc;
        if (v > 32'd999) begin
            e.lat = 1;
            e.a1 = glyph(10); e.b1 = glyph(10); e.c1 = glyph(10);
            e.a2 = ~glyph(10); e.b2 = ~glyph(10); e.c2 = ~glyph(10);
        end else begin
            h = int'(v) / 100;
            t = (int'(v) / 10) % 10;
            o = int'(v) % 10;
            e.lat = 11;
            e.a1 = glyph(o);
            e.b1 = (h == 0 && t == 0) ? glyph(11) : glyph(t);
            e.c1 = (h == 0) ? glyph(11) : glyph(h);
            e.a2 = ~glyph(o); e.b2 = ~glyph(t); e.c2 = ~glyph(h);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Monitor: resolve what the edge just passed did, then predict the next edge.
    always @(negedge clock) begin
        exp_t e;
        if (pend_reset) begin
            sb.delete();
            free_at = cyc;
            started = 1'b1;
            cur.a1 = glyph(0);  cur.b1 = glyph(11); cur.c1 = glyph(11);
            cur.a2 = ~glyph(0); cur.b2 = ~glyph(0); cur.c2 = ~glyph(0);
        end else if (started && prev_ready === 1'b0 && ready1 === 1'b1) begin
            chk("sb_entry_present", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                cur = e;
            end
        end
        if (started) begin
            chk("ready1", 32'(ready1), 32'(cyc >= free_at));
            chk("ready2", 32'(ready2), 32'(cyc >= free_at));
            chk("outputA", 32'(a1), 32'(cur.a1));
            chk("outputB", 32'(b1), 32'(cur.b1));
            chk("outputC", 32'(c1), 32'(cur.c1));
            chk("outputA_nb", 32'(a2), 32'(cur.a2));
            chk("outputB_nb", 32'(b2), 32'(cur.b2));
            chk("outputC_nb", 32'(c2), 32'(cur.c2));
        end
        prev_ready = ready1;
        pend_reset = reset;
        if (!reset && started && out_valid && cyc >= free_at) begin
            e = model(out_data, cyc + 1);
            sb.push_back(e);
            free_at = cyc + 1 + e.lat;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready1 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic write(input logic [31:0] v);
        wait_ready();
        out_valid = 1'b1;
        out_data  = v;
        tick();
        out_valid = 1'b0;
        out_data  = $urandom;
    endtask

    function automatic logic [31:0] pick_value();
        int unsigned r = $urandom_range(0, 9);
        logic [31:0] edges [9] = '{0, 9, 10, 99, 100, 999, 1000, 1023, 1024};
        case (r)
            0, 1:    pick_value = edges[$urandom_range(0, 8)];
            2:       pick_value = $urandom;
            3:       pick_value = 32'($urandom_range(0, 99));
            default: pick_value = 32'($urandom_range(0, 999));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        out_valid = 1'b0;
        out_data = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        write(32'h000002A7);
        write(32'd7);
        write(32'd40);
        write(32'd1000);
        write(32'hFFFFFFFF);
        write(32'd999);

        write(32'd123);
        tick();
        tick();
        out_valid = 1'b1;
        out_data  = 32'd456;
        tick();
        out_valid = 1'b0;
        write(32'd456);

        write(32'd500);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (15) tick();

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    out_valid = 1'b1;
                    out_data  = pick_value();
                    tick();
                    out_valid = 1'b0;
                end
                2: begin
                    if ($urandom_range(0, 3) == 0) begin
                        reset = 1'b1;
                        tick();
                        reset = 1'b0;
                    end
                end
                default: write(pick_value());
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end

        wait_ready();
        tick();
        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
